// File: rtl/riscv_wb_arbiter.sv
// Arbitrates N_REQ writeback requesters onto one registered register-file write port.
// Latency 1 cycle; o_req_ready is gated off while the output stage is stalled by !i_wb_ready.
// Macro RISCV_WB_ARB_RR_EN selects round-robin priority; undefined gives fixed lowest-index priority.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int XLEN  = `XLEN
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*XLEN-1:0]      i_req_concat_data,
  input  logic [N_REQ*5-1:0]         i_req_concat_rd,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_wb_valid,
  output logic [4:0]                 o_wb_rd,
  output logic [XLEN-1:0]            o_wb_data,
  output logic [$clog2(N_REQ)-1:0]   o_wb_sel,
  input  logic                       i_wb_ready
);

  localparam int SW = $clog2(N_REQ);

  logic                r_wb_valid;
  logic [4:0]          r_wb_rd;
  logic [XLEN-1:0]     r_wb_data;
  logic [SW-1:0]       r_wb_sel;

  logic [SW-1:0]       w_start;
  logic [SW-1:0]       w_winner;
  logic [SW-1:0]       w_idx_s;
  logic                w_found;
  logic                w_load;
  logic                w_xfer;
  int                  w_idx;
  logic [XLEN-1:0]     w_data [N_REQ];
  logic [4:0]          w_rd   [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_slice
    assign w_data[k] = i_req_concat_data[k*XLEN +: XLEN];
    assign w_rd[k]   = i_req_concat_rd[k*5 +: 5];
  end

  // Grants are withheld during reset so no requester believes it was accepted.
  assign w_load = !i_rst && (!r_wb_valid || i_wb_ready);
  assign w_xfer = w_load && w_found;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    w_idx_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = int'(w_start) + i;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      w_idx_s = SW'(w_idx);
      if (!w_found && i_req_valid[w_idx_s]) begin
        w_found  = 1'b1;
        w_winner = w_idx_s;
      end
    end
  end

  assign o_req_ready = w_xfer ? (N_REQ'(1) << w_winner) : '0;

`ifdef RISCV_WB_ARB_RR_EN
  logic [SW-1:0] r_rr_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_winner == SW'(N_REQ-1)) ? '0 : w_winner + 1'b1;
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_sel   <= '0;
    end else if (w_load) begin
      r_wb_valid <= w_found;
      if (w_found) begin
        r_wb_rd   <= w_rd[w_winner];
        r_wb_data <= w_data[w_winner];
        r_wb_sel  <= w_winner;
      end
    end
  end

  assign o_wb_valid = r_wb_valid;
  assign o_wb_rd    = r_wb_rd;
  assign o_wb_data  = r_wb_data;
  assign o_wb_sel   = r_wb_sel;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: directed scenarios plus random traffic against a queue-level model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_wb_arbiter;

  localparam int N  = 3;
  localparam int XW = `XLEN;
`ifdef RISCV_WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [N-1:0]      i_req_valid;
  logic [N*XW-1:0]   i_req_concat_data;
  logic [N*5-1:0]    i_req_concat_rd;
  logic [N-1:0]      o_req_ready;
  logic              o_wb_valid;
  logic [4:0]        o_wb_rd;
  logic [XW-1:0]     o_wb_data;
  logic [1:0]        o_wb_sel;
  logic              i_wb_ready;

  riscv_wb_arbiter #(.N_REQ(N), .XLEN(XW)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_req_valid       (i_req_valid),
    .i_req_concat_data (i_req_concat_data),
    .i_req_concat_rd   (i_req_concat_rd),
    .o_req_ready       (o_req_ready),
    .o_wb_valid        (o_wb_valid),
    .o_wb_rd           (o_wb_rd),
    .o_wb_data         (o_wb_data),
    .o_wb_sel          (o_wb_sel),
    .i_wb_ready        (i_wb_ready)
  );

  always #5 i_clk = ~i_clk;

  // Requester-side state: pending request per source.
  logic          req_v  [N];
  logic [XW-1:0] req_d  [N];
  logic [4:0]    req_rd [N];

  // Reference model of the write port.
  logic          m_valid;
  logic [4:0]    m_rd;
  logic [XW-1:0] m_data;
  int            m_sel;
  int            m_ptr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_rd    = '0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  function automatic int model_winner();
    int start;
    if (i_rst) return -1;
    if (m_valid && !i_wb_ready) return -1;
    start = RR ? m_ptr : 0;
    for (int i = 0; i < N; i++) begin
      if (req_v[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_req_valid[k]                 = req_v[k];
      i_req_concat_data[k*XW +: XW]  = req_d[k];
      i_req_concat_rd[k*5 +: 5]      = req_rd[k];
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_valid"}, o_wb_valid, m_valid);
    check_val({tag, "_rd"},    o_wb_rd,    m_rd);
    check_val({tag, "_data"},  o_wb_data,  m_data);
    check_val({tag, "_sel"},   o_wb_sel,   m_sel);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(output int win);
    drive();
    #1;
    win = model_winner();
    check_val("ready", o_req_ready, (win >= 0) ? (64'd1 << win) : 64'd0);
    @(posedge i_clk);
    if (win >= 0) begin
      m_valid = 1'b1;
      m_data  = req_d[win];
      m_rd    = req_rd[win];
      m_sel   = win;
      m_ptr   = (win == N-1) ? 0 : win + 1;
    end else if (!m_valid || i_wb_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs("out");
  endtask

  task automatic do_reset_mid();
    drive();
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_async");
    check_val("rst_ready", o_req_ready, 0);
    @(posedge i_clk);
    #1;
    check_outputs("rst_hold");
    i_rst = 1'b0;
  endtask

  int win;
  logic [XW-1:0] d0;

  initial begin
    for (int k = 0; k < N; k++) begin
      req_v[k]  = 1'b0;
      req_d[k]  = '0;
      req_rd[k] = '0;
    end
    i_wb_ready = 1'b1;
    drive();
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_outputs("reset");
    i_rst = 1'b0;

    // Single requester on slot 1.
    req_v[1]  = 1'b1;
    req_d[1]  = 32'hDEADBEEF;
    req_rd[1] = 5'd7;
    drive();
    #1;
    check_val("single_ready", o_req_ready, 3'b010);
    cycle(win);
    check_val("single_valid", o_wb_valid, 1);
    check_val("single_data",  o_wb_data,  32'hDEADBEEF);
    check_val("single_rd",    o_wb_rd,    7);
    check_val("single_sel",   o_wb_sel,   1);

    // Reset mid-cycle with all valids up; then rotation from reset.
    for (int k = 0; k < N; k++) begin
      req_v[k]  = 1'b1;
      req_d[k]  = XW'($urandom);
      req_rd[k] = 5'(k + 10);
    end
    do_reset_mid();
    for (int r = 0; r < 6; r++) begin
      cycle(win);
      check_val("rot_sel",   o_wb_sel,   RR ? (r % 3) : 0);
      check_val("rot_valid", o_wb_valid, 1);
    end

    // Stall with the output held, then release.
    i_wb_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      cycle(win);
      check_val("stall_sel", o_wb_sel, RR ? 2 : 0);
    end
    i_wb_ready = 1'b1;
    cycle(win);
    check_val("stall_wrap", o_wb_sel, 0);
    d0 = req_d[0];

    // Idle drain.
    for (int k = 0; k < N; k++) req_v[k] = 1'b0;
    cycle(win);
    check_val("drain_valid", o_wb_valid, 0);
    check_val("drain_data",  o_wb_data,  d0);
    check_val("drain_sel",   o_wb_sel,   0);

    // Requesters 1 and 2 competing.
    req_v[1] = 1'b1;
    req_v[2] = 1'b1;
    cycle(win);
    check_val("prio_sel0", o_wb_sel, 1);
    cycle(win);
    check_val("prio_sel1", o_wb_sel, RR ? 2 : 1);

    // Random traffic: a requester holds until accepted, then may issue again.
    for (int k = 0; k < N; k++) req_v[k] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      i_wb_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (!req_v[k] && $urandom_range(0, 1) == 1) begin
          req_v[k]  = 1'b1;
          req_d[k]  = XW'($urandom);
          req_rd[k] = 5'($urandom_range(0, 31));
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        do_reset_mid();
      end else begin
        cycle(win);
        if (win >= 0) req_v[win] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
